// File: rtl/rgb_light_pkg.sv
// rgb_light_pkg
// Shared definitions for the RGB light interface (lighter and checker):
//   - RGB_C0..RGB_C7 : {r,g,b} code driven for each 3-bit count value
//   - seq_state_e    : sequence-checker FSM state encoding
//   - count_to_rgb() : forward map, count -> rgb code
package rgb_light_pkg;

    localparam logic [2:0] RGB_C0 = 3'b111;
    localparam logic [2:0] RGB_C1 = 3'b010;
    localparam logic [2:0] RGB_C2 = 3'b011;
    localparam logic [2:0] RGB_C3 = 3'b100;
    localparam logic [2:0] RGB_C4 = 3'b110;
    localparam logic [2:0] RGB_C5 = 3'b101;
    localparam logic [2:0] RGB_C6 = 3'b001;
    localparam logic [2:0] RGB_C7 = 3'b000;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } seq_state_e;

    function automatic logic [2:0] count_to_rgb(input logic [2:0] count);
        logic [2:0] code;
        case (count)
            3'd0:    code = RGB_C0;
            3'd1:    code = RGB_C1;
            3'd2:    code = RGB_C2;
            3'd3:    code = RGB_C3;
            3'd4:    code = RGB_C4;
            3'd5:    code = RGB_C5;
            3'd6:    code = RGB_C6;
            default: code = RGB_C7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rgb_to_count.sv
// rgb_to_count
// Combinational decode of an rgb light code back to its count value.
// Exact inverse of count_to_rgb(); every 3-bit code is legal.
// Ports:
//   rgb   in  3  light code {r,g,b}
//   count out 3  decoded count value
module rgb_to_count
    import rgb_light_pkg::*;
(
    input  logic [2:0] rgb,
    output logic [2:0] count
);

    always_comb begin
        count = 3'd0;
        case (rgb)
            RGB_C0:  count = 3'd0;
            RGB_C1:  count = 3'd1;
            RGB_C2:  count = 3'd2;
            RGB_C3:  count = 3'd3;
            RGB_C4:  count = 3'd4;
            RGB_C5:  count = 3'd5;
            RGB_C6:  count = 3'd6;
            RGB_C7:  count = 3'd7;
            default: count = 3'd0;
        endcase
    end

endmodule

// File: rtl/rgb_sequence_checker.sv
// rgb_sequence_checker
// Receive-side monitor for the counter-driven RGB light interface. Decodes each
// valid sample, locks onto the +1 mod-8 sequence and flags bad steps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HUNT | no reference; next valid sample seeds the expected value
// ST_ACQ  | counting consecutive correct steps toward LOCK_CNT
// ST_LOCK | locked; mismatches pulse seq_error, flywheel the expectation
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-low reset
//   rgb_valid  in   1      rgb carries a sample this cycle
//   rgb        in   3      light code {r,g,b}
//   count_out  out  3      decoded count of last valid sample
//   count_vld  out  1      pulse: count_out updated
//   locked     out  1      FSM is in ST_LOCK
//   seq_error  out  1      pulse: mismatch while locked
//   wrap       out  1      pulse: accepted 7 -> 0 step while locked
//   err_count  out  ERR_W  saturating count of seq_error pulses
module rgb_sequence_checker
    import rgb_light_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int MAX_MISS = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rgb_valid,
    input  logic [2:0]       rgb,
    output logic [2:0]       count_out,
    output logic             count_vld,
    output logic             locked,
    output logic             seq_error,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] LOCK_TC = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_TC = 4'(MAX_MISS);

    seq_state_e state_q, state_d;
    logic [2:0] expected_q, expected_d;
    logic [3:0] good_q, good_d;
    logic [3:0] miss_q, miss_d;
    logic       seq_err_d;
    logic       wrap_d;
    logic [2:0] dec;

    rgb_to_count u_rgb_to_count (
        .rgb   (rgb),
        .count (dec)
    );

    // State register plus registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            expected_q <= 3'd0;
            good_q     <= 4'd0;
            miss_q     <= 4'd0;
            count_out  <= 3'd0;
            count_vld  <= 1'b0;
            seq_error  <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            count_vld  <= rgb_valid;
            seq_error  <= seq_err_d;
            wrap       <= wrap_d;
            if (rgb_valid) begin
                count_out <= dec;
            end
            if (seq_err_d && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    // Next-state logic; nothing moves unless a sample is present
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        good_d     = good_q;
        miss_d     = miss_q;
        seq_err_d  = 1'b0;
        wrap_d     = 1'b0;
        if (rgb_valid) begin
            case (state_q)
                ST_HUNT: begin
                    expected_d = dec + 3'd1;
                    good_d     = 4'd0;
                    state_d    = ST_ACQ;
                end
                ST_ACQ: begin
                    // Resync to the observed value either way; only the run length differs
                    expected_d = dec + 3'd1;
                    if (dec == expected_q) begin
                        if (good_q + 4'd1 == LOCK_TC) begin
                            state_d = ST_LOCK;
                            good_d  = 4'd0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCK: begin
                    if (dec == expected_q) begin
                        miss_d     = 4'd0;
                        expected_d = dec + 3'd1;
                        wrap_d     = (dec == 3'd0);
                    end else begin
                        // Flywheel: advance from our own expectation, not the bad sample
                        seq_err_d  = 1'b1;
                        expected_d = expected_q + 3'd1;
                        if (miss_q + 4'd1 == MISS_TC) begin
                            state_d = ST_HUNT;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        locked = (state_q == ST_LOCK);
    end

endmodule

// File: tb/tb_rgb_sequence_checker.sv
module tb_rgb_sequence_checker;
    import rgb_light_pkg::*;

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [2:0] rgb;
        logic       cvld;
        logic [2:0] cout;
        logic       lck;
        logic       serr;
        logic       wrp;
        logic [7:0] errc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic       a_reset, a_valid;
    logic [2:0] a_rgb, a_count_out;
    logic       a_count_vld, a_locked, a_seq_error, a_wrap;
    logic [7:0] a_err_count;

    // DUT B: narrow saturating error counter, very tolerant of misses
    logic       b_reset, b_valid;
    logic [2:0] b_rgb, b_count_out;
    logic       b_count_vld, b_locked, b_seq_error, b_wrap;
    logic [1:0] b_err_count;

    rgb_sequence_checker u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .rgb_valid (a_valid),
        .rgb       (a_rgb),
        .count_out (a_count_out),
        .count_vld (a_count_vld),
        .locked    (a_locked),
        .seq_error (a_seq_error),
        .wrap      (a_wrap),
        .err_count (a_err_count)
    );

    rgb_sequence_checker #(.LOCK_CNT(3), .MAX_MISS(15), .ERR_W(2)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .rgb_valid (b_valid),
        .rgb       (b_rgb),
        .count_out (b_count_out),
        .count_vld (b_count_vld),
        .locked    (b_locked),
        .seq_error (b_seq_error),
        .wrap      (b_wrap),
        .err_count (b_err_count)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t sb[$];
    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] code,
                                input logic cv, input logic [2:0] co, input logic lk,
                                input logic se, input logic wr, input logic [7:0] ec);
        vec_t t;
        t.rst_n = r;  t.v = v;    t.rgb = code;
        t.cvld = cv;  t.cout = co; t.lck = lk;
        t.serr = se;  t.wrp = wr; t.errc = ec;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    endtask

    // Drive one vector, push its expectation, then pop and compare once the
    // registered outputs have settled after the edge.
    task automatic run_row(input int dut, input int row, input vec_t t);
        vec_t       e;
        logic       cv, lk, se, wr;
        logic [2:0] co;
        logic [7:0] ec;
        string      p;
        if (dut == 0) begin
            a_reset = t.rst_n; a_valid = t.v; a_rgb = t.rgb;
        end else begin
            b_reset = t.rst_n; b_valid = t.v; b_rgb = t.rgb;
        end
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (dut == 0) begin
            p = "A"; cv = a_count_vld; co = a_count_out; lk = a_locked;
            se = a_seq_error; wr = a_wrap; ec = a_err_count;
        end else begin
            p = "B"; cv = b_count_vld; co = b_count_out; lk = b_locked;
            se = b_seq_error; wr = b_wrap; ec = {6'd0, b_err_count};
        end
        chk({p, ".count_vld"}, row, {7'd0, cv}, {7'd0, e.cvld});
        chk({p, ".count_out"}, row, {5'd0, co}, {5'd0, e.cout});
        chk({p, ".locked"},    row, {7'd0, lk}, {7'd0, e.lck});
        chk({p, ".seq_error"}, row, {7'd0, se}, {7'd0, e.serr});
        chk({p, ".wrap"},      row, {7'd0, wr}, {7'd0, e.wrp});
        chk({p, ".err_count"}, row, ec, e.errc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b0; a_valid = 1'b0; a_rgb = 3'd0;
        b_reset = 1'b0; b_valid = 1'b0; b_rgb = 3'd0;

        // ---- DUT A: reset, lock, skip, double miss, idle gap, error build-up, reset ----
        //                rst v  rgb     cv cout lk se wr err
        tab_a.push_back(mk(0, 1, RGB_C3, 0, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(0, 0, RGB_C0, 0, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C1, 1, 1, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C2, 1, 2, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C3, 1, 3, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C4, 1, 4, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C5, 1, 5, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C6, 1, 6, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C7, 1, 7, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 0, 1, 0));
        tab_a.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 0, 0, 0));
        // skip 4: one error, flywheel expects 5 next
        tab_a.push_back(mk(1, 1, RGB_C2, 1, 2, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C3, 1, 3, 1, 0, 0, 0));
        tab_a.push_back(mk(1, 1, RGB_C5, 1, 5, 1, 1, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C5, 1, 5, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C6, 1, 6, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C7, 1, 7, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 0, 1, 1));
        tab_a.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C2, 1, 2, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C3, 1, 3, 1, 0, 0, 1));
        tab_a.push_back(mk(1, 1, RGB_C4, 1, 4, 1, 0, 0, 1));
        // repeat 4 twice: second miss drops lock
        tab_a.push_back(mk(1, 1, RGB_C4, 1, 4, 1, 1, 0, 2));
        tab_a.push_back(mk(1, 1, RGB_C4, 1, 4, 0, 1, 0, 3));
        // re-acquire, with one mismatch in ACQUIRE that restarts the run
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 0, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C1, 1, 1, 0, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C5, 1, 5, 0, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C6, 1, 6, 0, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C7, 1, 7, 0, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 0, 0, 3));
        // idle gap with garbage on rgb
        tab_a.push_back(mk(1, 0, RGB_C5, 0, 0, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 0, RGB_C2, 0, 0, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 0, RGB_C7, 0, 0, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 0, RGB_C0, 0, 0, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 0, RGB_C4, 0, 0, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 0, 0, 3));
        tab_a.push_back(mk(1, 1, RGB_C2, 1, 2, 1, 0, 0, 3));
        // alternate bad/good to build err_count to 7 without losing lock
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 1, 0, 4));
        tab_a.push_back(mk(1, 1, RGB_C4, 1, 4, 1, 0, 0, 4));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 1, 0, 5));
        tab_a.push_back(mk(1, 1, RGB_C6, 1, 6, 1, 0, 0, 5));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 1, 0, 6));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 0, 1, 6));
        tab_a.push_back(mk(1, 1, RGB_C0, 1, 0, 1, 1, 0, 7));
        tab_a.push_back(mk(1, 1, RGB_C2, 1, 2, 1, 0, 0, 7));

        foreach (tab_a[i]) run_row(0, i, tab_a[i]);

        // Hand sequence: reset while locked with err_count=7, then restart from HUNT
        run_row(0, 100, mk(0, 1, RGB_C3, 0, 0, 0, 0, 0, 0));
        run_row(0, 101, mk(1, 0, RGB_C3, 0, 0, 0, 0, 0, 0));
        run_row(0, 102, mk(1, 1, RGB_C5, 1, 5, 0, 0, 0, 0));
        run_row(0, 103, mk(1, 1, RGB_C5, 1, 5, 0, 0, 0, 0));

        // ---- DUT B: err_count saturation (ERR_W=2, MAX_MISS=15) ----
        tab_b.push_back(mk(0, 1, RGB_C0, 0, 0, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 1, RGB_C0, 1, 0, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 1, RGB_C2, 1, 2, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 1, RGB_C3, 1, 3, 1, 0, 0, 0));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 1, 0, 1));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 1, 0, 2));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 1, 0, 3));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 1, 0, 3));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 1, 0, 3));
        tab_b.push_back(mk(1, 1, RGB_C1, 1, 1, 1, 0, 0, 3));

        foreach (tab_b[i]) run_row(1, i, tab_b[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
